// File: rtl/ysyx_24070016_ifu_fetch.sv
// Instruction fetch stage: owns the PC, issues one read per instruction and
// buffers the returned word for decode, honouring execute redirects and halt.
module ysyx_24070016_ifu_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter bit          HALT_ON_ERR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_arvalid,
  output logic [31:0] mem_araddr,
  input  logic        mem_arready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  output logic        mem_rready,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        if_err,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT,
    S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        err_q, err_d;
  logic        kill_q, kill_d;
  logic        halted_q, halted_d;

  logic [31:0] redirect_tgt;
  logic [31:0] pc_plus4;
  logic        halt_now;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign pc_plus4     = pc_q + 32'd4;
  assign halt_now     = halted_q | halt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= 32'd0;
      inst_q     <= 32'd0;
      if_pc_q    <= 32'd0;
      err_q      <= 1'b0;
      kill_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      inst_q     <= inst_d;
      if_pc_q    <= if_pc_d;
      err_q      <= err_d;
      kill_q     <= kill_d;
      halted_q   <= halted_d;
    end
  end

  // A request already on the bus cannot be withdrawn, so a redirect while it is
  // in flight only marks it killed; the response is dropped and pc refetched.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    inst_d     = inst_q;
    if_pc_d    = if_pc_q;
    err_d      = err_q;
    kill_d     = kill_q;
    halted_d   = halted_q | halt;

    case (state_q)
      S_IDLE: begin
        if (redirect_valid) begin
          pc_d       = redirect_tgt;
          req_addr_d = redirect_tgt;
        end else begin
          req_addr_d = pc_q;
        end
        state_d = halt_now ? S_HALT : S_REQ;
      end

      S_REQ: begin
        if (redirect_valid) begin
          pc_d   = redirect_tgt;
          kill_d = 1'b1;
        end
        if (mem_arready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (redirect_valid) begin
          pc_d   = redirect_tgt;
          kill_d = 1'b1;
        end
        if (mem_rvalid) begin
          if (halt_now) begin
            kill_d  = 1'b0;
            state_d = S_HALT;
          end else if (kill_q || redirect_valid) begin
            kill_d     = 1'b0;
            req_addr_d = redirect_valid ? redirect_tgt : pc_q;
            state_d    = S_REQ;
          end else begin
            inst_d  = mem_rdata;
            if_pc_d = req_addr_q;
            err_d   = (mem_rresp != 2'b00);
            state_d = S_OUT;
          end
        end
      end

      // A redirect drops the buffered instruction even when decode takes it.
      S_OUT: begin
        if (redirect_valid) begin
          pc_d       = redirect_tgt;
          req_addr_d = redirect_tgt;
          state_d    = halt_now ? S_HALT : S_REQ;
        end else if (id_ready) begin
          pc_d       = pc_plus4;
          req_addr_d = pc_plus4;
          state_d    = (halt_now || (HALT_ON_ERR && err_q)) ? S_HALT : S_REQ;
        end
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_HALT;
      end
    endcase
  end

  assign mem_arvalid = (state_q == S_REQ);
  assign mem_araddr  = req_addr_q;
  assign mem_rready  = (state_q == S_WAIT);
  assign if_valid    = (state_q == S_OUT);
  assign if_inst     = inst_q;
  assign if_pc       = if_pc_q;
  assign if_err      = err_q;

endmodule

// File: tb/tb_ysyx_24070016_ifu_fetch.sv
// Self-checking bench for ysyx_24070016_ifu_fetch: cycle vector table, directed
// corner sequences, and a randomized run against an architectural PC model.
module tb_ysyx_24070016_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] I1 = 32'h0010_0093;
  localparam logic [31:0] I2 = 32'h0020_8113;
  localparam logic [31:0] I3 = 32'h0031_0193;
  localparam logic [31:0] I4 = 32'h0041_8213;
  localparam logic [31:0] I5 = 32'h0052_0293;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_arvalid;
  logic [31:0] mem_araddr;
  logic        mem_arready;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rready;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_err;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ysyx_24070016_ifu_fetch #(
    .RESET_PC    (RESET_PC),
    .HALT_ON_ERR (1'b1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_arvalid    (mem_arvalid),
    .mem_araddr     (mem_araddr),
    .mem_arready    (mem_arready),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .mem_rresp      (mem_rresp),
    .mem_rready     (mem_rready),
    .if_valid       (if_valid),
    .if_inst        (if_inst),
    .if_pc          (if_pc),
    .if_err         (if_err),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
  );

  typedef struct packed {
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
  } stim_t;

  typedef struct {
    stim_t       in;
    logic        exp_arvalid;
    logic [31:0] exp_araddr;
    logic        exp_rready;
    logic        exp_if_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  // Contents of the randomized-phase memory: a fixed scramble of the address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  function automatic stim_t st(input logic ar, input logic rv, input logic [31:0] rd,
                               input logic [1:0] rr, input logic idr, input logic rdv,
                               input logic [31:0] rdpc, input logic h);
    stim_t s;
    s.arready        = ar;
    s.rvalid         = rv;
    s.rdata          = rd;
    s.rresp          = rr;
    s.id_ready       = idr;
    s.redirect_valid = rdv;
    s.redirect_pc    = rdpc;
    s.halt           = h;
    return s;
  endfunction

  function automatic vec_t mkv(input stim_t s, input logic arv, input logic [31:0] addr,
                               input logic rr, input logic v, input logic [31:0] pc,
                               input logic [31:0] inst, input logic err);
    vec_t e;
    e.in           = s;
    e.exp_arvalid  = arv;
    e.exp_araddr   = addr;
    e.exp_rready   = rr;
    e.exp_if_valid = v;
    e.exp_pc       = pc;
    e.exp_inst     = inst;
    e.exp_err      = err;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic checkBit(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
    end
  endtask

  task automatic setInputs(input stim_t s);
    mem_arready    = s.arready;
    mem_rvalid     = s.rvalid;
    mem_rdata      = s.rdata;
    mem_rresp      = s.rresp;
    id_ready       = s.id_ready;
    redirect_valid = s.redirect_valid;
    redirect_pc    = s.redirect_pc;
    halt           = s.halt;
  endtask

  // Drive one cycle's inputs, then sample just after the next rising edge.
  task automatic applyStimulus(input stim_t s);
    setInputs(s);
    @(posedge clk);
    #1;
  endtask

  task automatic expectCtl(input string tag, input logic arv, input logic rr, input logic v);
    checkBit({tag, "_arvalid"}, mem_arvalid, arv);
    checkBit({tag, "_rready"}, mem_rready, rr);
    checkBit({tag, "_if_valid"}, if_valid, v);
  endtask

  task automatic expectOut(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                           input logic err);
    checkBit({tag, "_if_valid"}, if_valid, 1'b1);
    checkOutput({tag, "_if_pc"}, if_pc, pc);
    checkOutput({tag, "_if_inst"}, if_inst, inst);
    checkBit({tag, "_if_err"}, if_err, err);
  endtask

  task automatic checkRow(input int idx, input vec_t e);
    string tag;
    tag = $sformatf("vec%0d", idx);
    expectCtl(tag, e.exp_arvalid, e.exp_rready, e.exp_if_valid);
    if (e.exp_arvalid) checkOutput({tag, "_araddr"}, mem_araddr, e.exp_araddr);
    if (e.exp_if_valid) begin
      checkOutput({tag, "_if_pc"}, if_pc, e.exp_pc);
      checkOutput({tag, "_if_inst"}, if_inst, e.exp_inst);
      checkBit({tag, "_if_err"}, if_err, e.exp_err);
    end
  endtask

  // Leaves the bench just after a rising edge with rst_n released: the IDLE cycle.
  task automatic doReset(input string tag);
    setInputs(st(0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    expectCtl({tag, "_rst"}, 1'b0, 1'b0, 1'b0);
    checkOutput({tag, "_rst_araddr"}, mem_araddr, 32'd0);
    checkOutput({tag, "_rst_if_pc"}, if_pc, 32'd0);
    checkOutput({tag, "_rst_if_inst"}, if_inst, 32'd0);
    checkBit({tag, "_rst_if_err"}, if_err, 1'b0);
    rst_n = 1'b1;
  endtask

  stim_t idle_s;
  stim_t ar_s;
  vec_t  vecs[19];

  initial begin
    idle_s = st(0, 0, 0, 0, 0, 0, 0, 0);
    ar_s   = st(1, 0, 0, 0, 0, 0, 0, 0);

    // Zero-wait fetches, a 5-cycle decode stall, then redirect + id_ready together.
    vecs[0]  = mkv(ar_s,                                    0, 0,            0, 0, 0,            0,  0);
    vecs[1]  = mkv(ar_s,                                    1, 32'h80000000, 0, 0, 0,            0,  0);
    vecs[2]  = mkv(st(0, 1, I1, 0, 0, 0, 0, 0),             0, 0,            1, 0, 0,            0,  0);
    vecs[3]  = mkv(st(0, 0, 0, 0, 1, 0, 0, 0),              0, 0,            0, 1, 32'h80000000, I1, 0);
    vecs[4]  = mkv(ar_s,                                    1, 32'h80000004, 0, 0, 0,            0,  0);
    vecs[5]  = mkv(st(0, 1, I2, 0, 0, 0, 0, 0),             0, 0,            1, 0, 0,            0,  0);
    for (int i = 6; i <= 10; i++)
      vecs[i] = mkv(ar_s,                                   0, 0,            0, 1, 32'h80000004, I2, 0);
    vecs[11] = mkv(st(0, 0, 0, 0, 1, 0, 0, 0),              0, 0,            0, 1, 32'h80000004, I2, 0);
    vecs[12] = mkv(ar_s,                                    1, 32'h80000008, 0, 0, 0,            0,  0);
    vecs[13] = mkv(st(0, 1, I3, 0, 0, 0, 0, 0),             0, 0,            1, 0, 0,            0,  0);
    vecs[14] = mkv(st(0, 0, 0, 0, 1, 1, 32'h80000203, 0),   0, 0,            0, 1, 32'h80000008, I3, 0);
    vecs[15] = mkv(ar_s,                                    1, 32'h80000200, 0, 0, 0,            0,  0);
    vecs[16] = mkv(st(0, 1, I4, 0, 0, 0, 0, 0),             0, 0,            1, 0, 0,            0,  0);
    vecs[17] = mkv(st(0, 0, 0, 0, 1, 0, 0, 0),              0, 0,            0, 1, 32'h80000200, I4, 0);
    vecs[18] = mkv(ar_s,                                    1, 32'h80000204, 0, 0, 0,            0,  0);

    doReset("t1");
    // IDLE, REQ and WAIT occupy cycles 1-3, so if_valid is first seen in cycle 4.
    for (int i = 0; i < 19; i++) begin
      checkRow(i, vecs[i]);
      applyStimulus(vecs[i].in);
    end

    // Redirect while WAIT, response two cycles later must be discarded.
    expectCtl("t3_w0", 0, 1, 0);
    applyStimulus(st(0, 0, 0, 0, 1, 1, 32'h80000100, 0));
    expectCtl("t3_w1", 0, 1, 0);
    applyStimulus(st(0, 0, 0, 0, 1, 0, 0, 0));
    expectCtl("t3_w2", 0, 1, 0);
    applyStimulus(st(0, 1, 32'hDEADBEEF, 0, 1, 0, 0, 0));
    expectCtl("t3_req", 1, 0, 0);
    checkOutput("t3_araddr", mem_araddr, 32'h80000100);
    applyStimulus(ar_s);
    expectCtl("t3_w3", 0, 1, 0);
    applyStimulus(st(0, 1, I5, 0, 0, 0, 0, 0));
    expectOut("t3_out", 32'h80000100, I5, 0);
    applyStimulus(st(0, 0, 0, 0, 1, 0, 0, 0));

    // Halt during REQ with arready held off three cycles.
    for (int i = 0; i < 3; i++) begin
      expectCtl($sformatf("t5_req%0d", i), 1, 0, 0);
      checkOutput($sformatf("t5_araddr%0d", i), mem_araddr, 32'h80000104);
      applyStimulus(st(0, 0, 0, 0, 0, 0, 0, (i == 0)));
    end
    expectCtl("t5_req3", 1, 0, 0);
    checkOutput("t5_araddr3", mem_araddr, 32'h80000104);
    applyStimulus(ar_s);
    expectCtl("t5_wait", 0, 1, 0);
    applyStimulus(st(0, 1, I1, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) begin
      expectCtl($sformatf("t5_halt%0d", i), 0, 0, 0);
      applyStimulus(st(1, 1, I2, 0, 1, 1, 32'h80000040, 0));
    end

    // PC wrap at the top of the address space, then an error response halts.
    doReset("t6");
    applyStimulus(ar_s);
    checkOutput("t6_araddr0", mem_araddr, 32'h80000000);
    applyStimulus(ar_s);
    applyStimulus(st(0, 1, I1, 0, 0, 0, 0, 0));
    expectOut("t6_out0", 32'h80000000, I1, 0);
    applyStimulus(st(0, 0, 0, 0, 0, 1, 32'hFFFFFFFE, 0));
    expectCtl("t6_req1", 1, 0, 0);
    checkOutput("t6_araddr1", mem_araddr, 32'hFFFFFFFC);
    applyStimulus(ar_s);
    applyStimulus(st(0, 1, I2, 0, 0, 0, 0, 0));
    expectOut("t6_out1", 32'hFFFFFFFC, I2, 0);
    applyStimulus(st(0, 0, 0, 0, 1, 0, 0, 0));
    expectCtl("t6_req2", 1, 0, 0);
    checkOutput("t6_araddr_wrap", mem_araddr, 32'h00000000);
    applyStimulus(ar_s);
    applyStimulus(st(0, 1, I3, 2'b10, 0, 0, 0, 0));
    expectOut("t6_err", 32'h00000000, I3, 1);
    applyStimulus(idle_s);
    expectOut("t6_err_hold", 32'h00000000, I3, 1);
    applyStimulus(st(0, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 4; i++) begin
      expectCtl($sformatf("t6_halt%0d", i), 0, 0, 0);
      applyStimulus(st(1, 1, I4, 0, 1, 0, 0, 0));
    end

    // Asynchronous reset pulse in the middle of a WAIT cycle.
    doReset("t6b");
    applyStimulus(ar_s);
    applyStimulus(ar_s);
    expectCtl("t6b_wait", 0, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    expectCtl("t6b_async", 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    expectCtl("t6b_idle", 0, 0, 0);
    applyStimulus(ar_s);
    expectCtl("t6b_req", 1, 0, 0);
    checkOutput("t6b_araddr", mem_araddr, RESET_PC);

    // Randomized run: random memory latency, backpressure and redirects.
    begin
      logic [31:0] exp_pc;
      logic        pend;
      logic [31:0] pend_addr;
      int          cnt;
      logic        prev_stall;
      logic [31:0] prev_addr;
      int          accepted;
      stim_t       s;

      doReset("rnd");
      exp_pc     = RESET_PC;
      pend       = 1'b0;
      pend_addr  = 32'd0;
      cnt        = 0;
      prev_stall = 1'b0;
      prev_addr  = 32'd0;
      accepted   = 0;

      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (prev_stall) checkOutput("rnd_araddr_hold", mem_araddr, prev_addr);

        s = idle_s;
        s.arready        = ($urandom_range(0, 3) != 0);
        s.rvalid         = pend && (cnt == 0);
        s.rdata          = pend ? memfn(pend_addr) : 32'hBAD0_BAD0;
        s.id_ready       = ($urandom_range(0, 2) != 0);
        s.redirect_valid = (cyc > 0) && ($urandom_range(0, 11) == 0);
        s.redirect_pc    = RESET_PC + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);

        if (if_valid) begin
          checkOutput("rnd_if_pc", if_pc, exp_pc);
          checkOutput("rnd_if_inst", if_inst, memfn(exp_pc));
        end
        if (mem_arvalid && s.arready) checkBit("rnd_single_outstanding", pend, 1'b0);

        if (s.redirect_valid) begin
          exp_pc = s.redirect_pc & 32'hFFFF_FFFC;
        end else if (if_valid && s.id_ready) begin
          exp_pc   = exp_pc + 32'd4;
          accepted = accepted + 1;
        end

        prev_stall = mem_arvalid && !s.arready;
        prev_addr  = mem_araddr;
        if (s.rvalid && mem_rready) pend = 1'b0;
        else if (pend && cnt > 0) cnt = cnt - 1;
        if (mem_arvalid && s.arready) begin
          pend      = 1'b1;
          pend_addr = mem_araddr;
          cnt       = $urandom_range(0, 3);
        end

        applyStimulus(s);
      end
      checkBit("rnd_progress", accepted >= 100, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
